// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a registered 4:1 data mux with a bounded grant hold.
// Optional macro MUX_ARB_LOCK_EN adds a lock input that suppresses the hold-limit release.
module mux_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MUX_ARB_LOCK_EN
    input  logic              lock,
`endif
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld
);

    localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_vld_q, dout_vld_d;

    logic                lock_act;
    logic                found;
    logic [1:0]          win;
    logic [1:0]          idx;
    logic [DATA_W-1:0]   mux_out;
    logic                others;
    logic                release_now;
    logic                grant_new;

`ifdef MUX_ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    // First set request found when scanning upward from ptr, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    mux_out = din0;
            2'd1:    mux_out = din1;
            2'd2:    mux_out = din2;
            default: mux_out = din3;
        endcase
    end

    assign others = |(req & ~gnt_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        release_now = 1'b0;
        grant_new   = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) grant_new = 1'b1;
            end
            BUSY: begin
                dout_d      = mux_out;
                dout_vld_d  = 1'b1;
                release_now = !req[sel_q] ||
                              ((hold_cnt_q == HOLD_LIM) && others && !lock_act);
                if (release_now) begin
                    if (found) begin
                        grant_new = 1'b1;
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end else if (hold_cnt_q != HOLD_LIM) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Current owner sits last in the scan order, so a re-request loses to any waiter.
        if (grant_new) begin
            gnt_d      = 4'b0001 << win;
            sel_d      = win;
            ptr_d      = win + 2'd1;
            hold_cnt_d = CNT_W'(1);
            state_d    = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: per-cycle model compare plus directed literal checks.
module tb_mux_rr_arbiter;

    localparam int DW   = 4;
    localparam int HMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = 4'b0000;
    logic [DW-1:0] din [4];
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] dout;
    logic          dout_vld;
`ifdef MUX_ARB_LOCK_EN
    logic          lock = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: owner index (-1 = none), scan start, hold count.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_hold  = 0;
    int            m_sel   = 0;
    logic [DW-1:0] m_dout  = '0;
    bit            m_vld   = 1'b0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_W(DW), .HOLD_MAX(HMAX)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef MUX_ARB_LOCK_EN
        .lock     (lock),
`endif
        .req      (req),
        .din0     (din[0]),
        .din1     (din[1]),
        .din2     (din[2]),
        .din3     (din[3]),
        .gnt      (gnt),
        .sel      (sel),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit lock_eff;
        bit others;
        int w;
`ifdef MUX_ARB_LOCK_EN
        lock_eff = lock;
`else
        lock_eff = 1'b0;
`endif
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_dout = '0; m_vld = 1'b0;
        end else if (m_owner < 0) begin
            m_vld = 1'b0;
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_hold = 1;
            end
        end else begin
            m_dout = din[m_owner];
            m_vld  = 1'b1;
            others = (req & ~(4'b0001 << m_owner)) != 4'b0000;
            if (!req[m_owner] || (m_hold >= HMAX && others && !lock_eff)) begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_hold = 1;
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold < HMAX) begin
                m_hold++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : 32'(4'b0001 << m_owner));
            chk("model_sel", 32'(sel), 32'(m_sel));
            chk("model_dout", 32'(dout), 32'(m_dout));
            chk("model_vld", 32'(dout_vld), 32'(m_vld));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        din[0] = 4'h1; din[1] = 4'h2; din[2] = 4'h4; din[3] = 4'h8;
        tick(2);
        cmp_en = 1'b1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_vld", 32'(dout_vld), 32'h0);
        rst = 1'b0;

        // single requester: grant after one edge, data one edge later
        req = 4'b0001;
        tick(1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_sel", 32'(sel), 32'h0);
        chk("t1_vld_lag", 32'(dout_vld), 32'h0);
        tick(1);
        chk("t1_vld", 32'(dout_vld), 32'h1);
        chk("t1_dout", 32'(dout), 32'h1);
        req = 4'b0000;
        tick(1);
        chk("t1_rel_gnt", 32'(gnt), 32'h0);
        chk("t1_rel_vld", 32'(dout_vld), 32'h1);
        tick(1);
        chk("t1_idle_vld", 32'(dout_vld), 32'h0);
        chk("t1_idle_dout", 32'(dout), 32'h1);

        // all requesting: four cycles each, back-to-back rotation
        do_reset();
        req = 4'b1111;
        tick(1);
        for (int k = 0; k < 20; k++) begin
            chk("t2_rot_gnt", 32'(gnt), 32'(4'b0001 << ((k / 4) % 4)));
            if (k > 0) chk("t2_vld", 32'(dout_vld), 32'h1);
            for (int i = 0; i < 4; i++) din[i] = din[i] + DW'(i + 1);
            tick(1);
        end

        // lone requester is never rotated away
        req = 4'b0010;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            chk("t3_solo_gnt", 32'(gnt), 32'h2);
            tick(1);
        end
        req = 4'b0000;
        tick(2);

        // release by dropping request, then to idle
        do_reset();
        req = 4'b0101;
        tick(1);
        chk("t4_gnt0", 32'(gnt), 32'h1);
        tick(1);
        chk("t4_gnt0b", 32'(gnt), 32'h1);
        req = 4'b0100;
        tick(1);
        chk("t4_gnt2", 32'(gnt), 32'h4);
        chk("t4_sel2", 32'(sel), 32'h2);
        req = 4'b0000;
        tick(1);
        chk("t4_gnt_off", 32'(gnt), 32'h0);
        chk("t4_vld_tail", 32'(dout_vld), 32'h1);
        tick(1);
        chk("t4_vld_off", 32'(dout_vld), 32'h0);

        // reset in the middle of a grant
        req = 4'b0100;
        tick(2);
        chk("t5_pre_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        tick(1);
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_sel", 32'(sel), 32'h0);
        chk("t5_rst_dout", 32'(dout), 32'h0);
        chk("t5_rst_vld", 32'(dout_vld), 32'h0);
        rst = 1'b0;
        req = 4'b1001;
        tick(1);
        chk("t5_ptr0_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick(2);

`ifdef MUX_ARB_LOCK_EN
        do_reset();
        req  = 4'b0011;
        lock = 1'b1;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            chk("t6_lock_gnt", 32'(gnt), 32'h1);
            tick(1);
        end
        lock = 1'b0;
        tick(1);
        chk("t6_unlock_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick(2);
`endif

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
